// File: rtl/bp_pht_ctrl_if.sv
// Port bundle between bp_pht_ctrl (master) and its fetch/execute/table environment (slave).
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both high; valid never waits on ready.
interface bp_pht_ctrl_if #(
  parameter int w_ind = 4,
  parameter int DEPTH = 4,
  parameter int w_pc  = 32
);
  localparam int w_cnt = $clog2(DEPTH) + 1;

  logic             en;
  logic             br_valid;
  logic [w_pc-1:0]  br_pc;
  logic             br_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             res_valid;
  logic             res_taken;
  logic             res_ready;
  logic             mispredict;
  logic [w_cnt-1:0] inflight;
  logic             pht_en;
  logic             pht_predict;
  logic             pht_resolve;
  logic             pht_incr;
  logic             pht_decr;
  logic [w_ind-1:0] pht_index;
  logic             pht_final_pred;
  logic             pht_pred_valid;

  modport master (
    input  en, br_valid, br_pc, res_valid, res_taken, pht_final_pred, pht_pred_valid,
    output br_ready, pred_valid, pred_taken, res_ready, mispredict, inflight,
           pht_en, pht_predict, pht_resolve, pht_incr, pht_decr, pht_index
  );

  modport slave (
    output en, br_valid, br_pc, res_valid, res_taken, pht_final_pred, pht_pred_valid,
    input  br_ready, pred_valid, pred_taken, res_ready, mispredict, inflight,
           pht_en, pht_predict, pht_resolve, pht_incr, pht_decr, pht_index
  );
endinterface

// File: rtl/bp_pht_ctrl.sv
// Pattern-history-table initiator: predicts via the table, tracks in-flight predictions, issues counter updates.
// Optional gshare indexing and global history register enabled by defining BP_GSHARE_EN.
module bp_pht_ctrl #(
  parameter int w_ind = 4,
  parameter int DEPTH = 4,
  parameter int w_pc  = 32
) (
  input  logic             clk,
  input  logic             rst,
  bp_pht_ctrl_if.master    bus,
  output logic [1:0]       state_dbg,
  output logic [w_ind-1:0] ghr_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRED = 2'd1,
    WAIT = 2'd2,
    UPD  = 2'd3
  } state_t;

  state_t           state;
  logic [w_ind-1:0] cap_idx;
  logic             res_taken_q;
  logic             pred_valid_q;
  logic             pred_taken_q;
  logic             mispredict_q;

  logic [w_ind-1:0] q_idx  [DEPTH];
  logic             q_pred [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             res_ready_c;
  logic             br_ready_c;
  logic             res_fire;
  logic             br_fire;
  logic             push;
  logic [w_ind-1:0] req_idx;
  logic [w_ind-1:0] head_idx;
  logic             head_pred;
  logic             head_miss;

  wire unused_pc_bits = &{1'b0, bus.br_pc[w_pc-1:w_ind+2], bus.br_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [w_ind-1:0] ghr;
  logic [w_ind-1:0] q_ghr [DEPTH];
  assign req_idx = bus.br_pc[w_ind+1:2] ^ ghr;
  assign ghr_dbg = ghr;
`else
  assign req_idx = bus.br_pc[w_ind+1:2];
  assign ghr_dbg = '0;
`endif

  // Outcomes win over new requests, so br_ready drops whenever an outcome is being taken this cycle.
  assign res_ready_c = rst & bus.en & (state == IDLE) & (count != '0);
  assign br_ready_c  = rst & bus.en & (state == IDLE) & (count < CW'(DEPTH))
                       & ~(bus.res_valid & res_ready_c);
  assign res_fire    = bus.res_valid & res_ready_c;
  assign br_fire     = bus.br_valid & br_ready_c;
  assign push        = rst & (state == WAIT) & bus.pht_pred_valid;

  assign head_idx  = q_idx[rd_ptr];
  assign head_pred = q_pred[rd_ptr];
  assign head_miss = (res_taken_q != head_pred);

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]  <= cap_idx;
      q_pred[wr_ptr] <= bus.pht_final_pred;
`ifdef BP_GSHARE_EN
      q_ghr[wr_ptr]  <= ghr;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cap_idx      <= '0;
      res_taken_q  <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
`ifdef BP_GSHARE_EN
      ghr          <= '0;
`endif
    end else begin
      pred_valid_q <= 1'b0;
      mispredict_q <= 1'b0;
      case (state)
        IDLE: begin
          if (res_fire) begin
            res_taken_q <= bus.res_taken;
            state       <= UPD;
          end else if (br_fire) begin
            cap_idx <= req_idx;
            state   <= PRED;
          end
        end
        PRED: state <= WAIT;
        WAIT: begin
          if (bus.pht_pred_valid) begin
            wr_ptr       <= wr_ptr + 1'b1;
            count        <= count + 1'b1;
            pred_taken_q <= bus.pht_final_pred;
            pred_valid_q <= 1'b1;
`ifdef BP_GSHARE_EN
            ghr          <= {ghr[w_ind-2:0], bus.pht_final_pred};
`endif
            state        <= IDLE;
          end
        end
        UPD: begin
          // A wrong head invalidates every younger speculative entry, so the queue empties.
          if (head_miss) begin
            mispredict_q <= 1'b1;
            rd_ptr       <= wr_ptr;
            count        <= '0;
`ifdef BP_GSHARE_EN
            ghr          <= {q_ghr[rd_ptr][w_ind-2:0], res_taken_q};
`endif
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.br_ready    = br_ready_c;
  assign bus.res_ready   = res_ready_c;
  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.inflight    = count;

  assign bus.pht_en      = (state == PRED) | (state == UPD);
  assign bus.pht_predict = (state == PRED);
  assign bus.pht_resolve = (state == UPD);
  assign bus.pht_incr    = (state == UPD) & res_taken_q;
  assign bus.pht_decr    = (state == UPD) & ~res_taken_q;
  assign bus.pht_index   = (state == PRED) ? cap_idx :
                           (state == UPD)  ? head_idx : '0;

  assign state_dbg = state;
endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Directed bench for bp_pht_ctrl: reset, prediction latency, resolve priority, queue full/empty, mispredict flush.
module tb_bp_pht_ctrl;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int PW = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   state_dbg;
  logic [W-1:0] ghr_dbg;

  int checks = 0;
  int errors = 0;

  // expected entries {idx, pred, ghr_pre}, oldest first
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_ghr = '0;

  bp_pht_ctrl_if #(.w_ind(W), .DEPTH(D), .w_pc(PW)) bus ();

  bp_pht_ctrl #(.w_ind(W), .DEPTH(D), .w_pc(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg),
    .ghr_dbg   (ghr_dbg)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    checks++; if (bus.inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", bus.inflight); end
    checks++; if (bus.pred_valid !== 1'b0 || bus.mispredict !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", bus.pred_valid, bus.mispredict); end
    checks++; if (bus.br_ready !== 1'b0 || bus.res_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", bus.br_ready, bus.res_ready); end
    checks++; if ({bus.pht_en, bus.pht_predict, bus.pht_resolve, bus.pht_incr, bus.pht_decr} !== 5'b0) begin errors++; $display("FAIL reset_pht_pins got nonzero want 0"); end
    @(posedge clk); #1;
    rst = 1'b1;
    m_ghr = '0;
    exp_q.delete();
  endtask

  task automatic do_predict(input logic [PW-1:0] pc, input logic tp);
    logic [W-1:0] e_idx;
    e_idx = pc[W+1:2] ^ m_ghr;
    @(posedge clk); #1;
    bus.br_valid = 1'b1;
    bus.br_pc    = pc;
    @(negedge clk);
    checks++; if (bus.br_ready !== 1'b1) begin errors++; $display("FAIL pred_br_ready got %b want 1", bus.br_ready); end
    @(posedge clk); #1;
    bus.br_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.pht_predict !== 1'b1 || bus.pht_resolve !== 1'b0 || bus.pht_en !== 1'b1) begin errors++; $display("FAIL pred_pins got p%b r%b e%b want p1 r0 e1", bus.pht_predict, bus.pht_resolve, bus.pht_en); end
    checks++; if (bus.pht_index !== e_idx) begin errors++; $display("FAIL pred_index got %0h want %0h", bus.pht_index, e_idx); end
    @(posedge clk); #1;
    bus.pht_pred_valid = 1'b1;
    bus.pht_final_pred = tp;
    @(posedge clk); #1;
    bus.pht_pred_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.pred_valid !== 1'b1 || bus.pred_taken !== tp) begin errors++; $display("FAIL pred_out got v%b t%b want v1 t%b", bus.pred_valid, bus.pred_taken, tp); end
    checks++; if (bus.inflight !== 3'(exp_q.size() + 1)) begin errors++; $display("FAIL pred_inflight got %0d want %0d", bus.inflight, exp_q.size() + 1); end
    exp_q.push_back({e_idx, tp, m_ghr});
`ifdef BP_GSHARE_EN
    m_ghr = {m_ghr[W-2:0], tp};
    checks++; if (ghr_dbg !== m_ghr) begin errors++; $display("FAIL pred_ghr got %0h want %0h", ghr_dbg, m_ghr); end
`endif
  endtask

  task automatic do_resolve(input logic t);
    logic [2*W:0] h;
    logic         e_mis;
    int           e_cnt;
    h     = exp_q.pop_front();
    e_mis = (t != h[W]);
    if (e_mis) begin
      exp_q.delete();
`ifdef BP_GSHARE_EN
      m_ghr = {h[W-2:0], t};
`endif
    end
    e_cnt = exp_q.size();
    @(posedge clk); #1;
    bus.res_valid = 1'b1;
    bus.res_taken = t;
    @(negedge clk);
    checks++; if (bus.res_ready !== 1'b1) begin errors++; $display("FAIL res_ready got %b want 1", bus.res_ready); end
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.pht_resolve !== 1'b1 || bus.pht_predict !== 1'b0) begin errors++; $display("FAIL res_pins got r%b p%b want r1 p0", bus.pht_resolve, bus.pht_predict); end
    checks++; if (bus.pht_incr !== t || bus.pht_decr !== !t) begin errors++; $display("FAIL res_incdec got i%b d%b want i%b d%b", bus.pht_incr, bus.pht_decr, t, !t); end
    checks++; if (bus.pht_index !== h[2*W:W+1]) begin errors++; $display("FAIL res_index got %0h want %0h", bus.pht_index, h[2*W:W+1]); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.mispredict !== e_mis) begin errors++; $display("FAIL res_mispredict got %b want %b", bus.mispredict, e_mis); end
    checks++; if (bus.inflight !== 3'(e_cnt)) begin errors++; $display("FAIL res_inflight got %0d want %0d", bus.inflight, e_cnt); end
`ifdef BP_GSHARE_EN
    checks++; if (ghr_dbg !== m_ghr) begin errors++; $display("FAIL res_ghr got %0h want %0h", ghr_dbg, m_ghr); end
`endif
  endtask

  task automatic test_predict();
    do_predict(32'h28, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    bus.br_valid = 1'b1;
    bus.br_pc    = 32'h28;
    @(posedge clk); #1;
    bus.br_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pht_pred_valid = 1'b1;
    bus.pht_final_pred = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL midwait_state got %0d want 2", state_dbg); end
    @(posedge clk); #1;
    bus.pht_pred_valid = 1'b0;
    @(negedge clk);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL midwait_idle got %0d want 0", state_dbg); end
    checks++; if (bus.inflight !== 3'd0 || bus.pred_valid !== 1'b0) begin errors++; $display("FAIL midwait_clear got n%0d v%b want n0 v0", bus.inflight, bus.pred_valid); end
    checks++; if ({bus.pht_en, bus.pht_predict, bus.pht_resolve, bus.pht_incr, bus.pht_decr} !== 5'b0) begin errors++; $display("FAIL midwait_pht_pins got nonzero want 0"); end
    @(posedge clk); #1;
    rst = 1'b1;
    m_ghr = '0;
    exp_q.delete();
  endtask

  task automatic test_resolve_priority();
    logic [2*W:0] h;
    h = exp_q.pop_front();
    @(posedge clk); #1;
    bus.res_valid = 1'b1;
    bus.res_taken = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_pc     = 32'h40;
    @(negedge clk);
    checks++; if (bus.br_ready !== 1'b0 || bus.res_ready !== 1'b1) begin errors++; $display("FAIL prio_ready got br%b res%b want br0 res1", bus.br_ready, bus.res_ready); end
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    bus.br_valid  = 1'b0;
    @(negedge clk);
    checks++; if (bus.pht_resolve !== 1'b1 || bus.pht_incr !== 1'b1 || bus.pht_predict !== 1'b0) begin errors++; $display("FAIL prio_upd got r%b i%b p%b want r1 i1 p0", bus.pht_resolve, bus.pht_incr, bus.pht_predict); end
    checks++; if (bus.pht_index !== h[2*W:W+1]) begin errors++; $display("FAIL prio_index got %0h want %0h", bus.pht_index, h[2*W:W+1]); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.mispredict !== 1'b0 || bus.inflight !== 3'd0) begin errors++; $display("FAIL prio_after got m%b n%0d want m0 n0", bus.mispredict, bus.inflight); end
  endtask

  task automatic test_empty_resolve();
    @(posedge clk); #1;
    bus.res_valid = 1'b1;
    bus.res_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.res_ready !== 1'b0 || bus.pht_resolve !== 1'b0) begin errors++; $display("FAIL empty_res cyc%0d got rdy%b rs%b want 00", i, bus.res_ready, bus.pht_resolve); end
    end
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
  endtask

  task automatic test_full();
    do_predict(32'h04, 1'b1);
    do_predict(32'h08, 1'b0);
    do_predict(32'h0C, 1'b1);
    do_predict(32'h10, 1'b1);
    @(negedge clk);
    bus.br_valid = 1'b1;
    bus.br_pc    = 32'h14;
    #1;
    checks++; if (bus.br_ready !== 1'b0 || bus.inflight !== 3'd4) begin errors++; $display("FAIL full_block got rdy%b n%0d want rdy0 n4", bus.br_ready, bus.inflight); end
    bus.br_valid = 1'b0;
    do_resolve(1'b1);
    @(negedge clk);
    bus.br_valid = 1'b1;
    #1;
    checks++; if (bus.br_ready !== 1'b1) begin errors++; $display("FAIL full_reopen got %b want 1", bus.br_ready); end
    bus.br_valid = 1'b0;
    do_resolve(1'b0);
    do_resolve(1'b0);
  endtask

  task automatic test_mispredict_flush();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_ghr = '0;
    exp_q.delete();
    do_predict(32'h28, 1'b1);
    do_predict(32'h30, 1'b0);
    do_resolve(1'b0);
    checks++; if (bus.inflight !== 3'd0) begin errors++; $display("FAIL flush_inflight got %0d want 0", bus.inflight); end
  endtask

  initial begin
    bus.en             = 1'b1;
    bus.br_valid       = 1'b0;
    bus.br_pc          = '0;
    bus.res_valid      = 1'b0;
    bus.res_taken      = 1'b0;
    bus.pht_final_pred = 1'b0;
    bus.pht_pred_valid = 1'b0;
    test_reset();
    test_predict();
    test_reset_mid_wait();
    test_predict();
    test_resolve_priority();
    test_empty_resolve();
    test_full();
    test_mispredict_flush();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
